// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_prefetch
// Description : Instruction fetch unit with a DEPTH-entry prefetch queue,
//               valid/ready hand-off to decode, and flushing redirects.
// Revision    : 1.0
// ============================================================================
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_err,
    output logic [31:0] err_pc
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0]   PTR_ONE    = AW'(1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic pop;
    logic push;

    assign im_addr   = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = pc_q[head];
    assign out_instr = instr_q[head];

    assign pop  = out_valid && out_ready;
    // A full queue may still accept a fetch when the head leaves this cycle.
    assign push = (state == ST_RUN) && en && !redirect_valid
                  && ((count < FULL_COUNT) || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            state     <= ST_RUN;
            fetch_err <= 1'b0;
            err_pc    <= '0;
        end else if (redirect_valid) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= redirect_pc;
            if (redirect_pc[1:0] == 2'b00) begin
                state     <= ST_RUN;
                fetch_err <= 1'b0;
            end else begin
                state     <= ST_HALT;
                fetch_err <= 1'b1;
                err_pc    <= redirect_pc;
            end
        end else begin
            if (push) begin
                tail     <= tail + PTR_ONE;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Queue payload needs no reset: count gates its visibility.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            pc_q[tail]    <= fetch_pc;
            instr_q[tail] <= im_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_prefetch
// Description : Bench for ifu_prefetch, DEPTH=4 and DEPTH=8 side by side.
// Revision    : 1.0
// ============================================================================
module tb_ifu_prefetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] im_addr_w   [2];
    logic [31:0] im_rdata_w  [2];
    logic [31:0] out_pc_w    [2];
    logic [31:0] out_instr_w [2];
    logic [31:0] err_pc_w    [2];
    logic        out_valid_w [2];
    logic        fetch_err_w [2];

    assign im_rdata_w[0] = im_addr_w[0] ^ 32'hFFFF_FFFF;
    assign im_rdata_w[1] = im_addr_w[1] ^ 32'hFFFF_FFFF;

    ifu_prefetch #(.RESET_PC(32'h0000_3000), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .en(en),
        .im_addr(im_addr_w[0]), .im_rdata(im_rdata_w[0]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_pc(out_pc_w[0]), .out_instr(out_instr_w[0]),
        .fetch_err(fetch_err_w[0]), .err_pc(err_pc_w[0])
    );

    ifu_prefetch #(.RESET_PC(32'h0000_3000), .DEPTH(8)) dut8 (
        .clk(clk), .reset(reset), .en(en),
        .im_addr(im_addr_w[1]), .im_rdata(im_rdata_w[1]),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_pc(out_pc_w[1]), .out_instr(out_instr_w[1]),
        .fetch_err(fetch_err_w[1]), .err_pc(err_pc_w[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: an ordered list of pending PCs per instance.
    logic [31:0] m_fpc   [2];
    logic [31:0] m_q_pc  [2][8];
    logic [31:0] m_errpc [2];
    int          m_cnt   [2];
    bit          m_halt  [2];
    bit          m_err   [2];

    function automatic int dep(int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic void model_step(int k);
        bit pop;
        bit push;
        pop = (m_cnt[k] != 0) && out_ready;
        if (!reset) begin
            m_fpc[k] = 32'h0000_3000; m_cnt[k] = 0;
            m_halt[k] = 1'b0; m_err[k] = 1'b0; m_errpc[k] = 32'h0;
        end else if (redirect_valid) begin
            m_cnt[k] = 0;
            m_fpc[k] = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                m_halt[k] = 1'b1; m_err[k] = 1'b1; m_errpc[k] = redirect_pc;
            end else begin
                m_halt[k] = 1'b0; m_err[k] = 1'b0;
            end
        end else begin
            push = !m_halt[k] && en && ((m_cnt[k] < dep(k)) || pop);
            if (pop) begin
                for (int i = 0; i < 7; i++) m_q_pc[k][i] = m_q_pc[k][i+1];
                m_cnt[k] = m_cnt[k] - 1;
            end
            if (push) begin
                m_q_pc[k][m_cnt[k]] = m_fpc[k];
                m_cnt[k] = m_cnt[k] + 1;
                m_fpc[k] = m_fpc[k] + 32'd4;
            end
        end
    endfunction

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3402;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_w[k] !== 1'b0 || fetch_err_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_flags d%0d: valid=%b err=%b required 0/0",
                         dep(k), out_valid_w[k], fetch_err_w[k]);
            end
            n_cmp++;
            if (im_addr_w[k] !== 32'h0000_3000 || err_pc_w[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_regs d%0d: im_addr=%h err_pc=%h required 00003000/00000000",
                         dep(k), im_addr_w[k], err_pc_w[k]);
            end
        end
        reset = 1'b1; redirect_valid = 1'b0; en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        exp = 32'h0000_3000;
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== exp || out_instr_w[k] !== ~exp) begin
                    n_bad++;
                    $display("FAIL stream d%0d c%0d: valid=%b pc=%h instr=%h required pc=%h instr=%h",
                             dep(k), c, out_valid_w[k], out_pc_w[k], out_instr_w[k], exp, ~exp);
                end
            end
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (im_addr_w[k] !== 32'h0000_3000 + 32'(4 * dep(k)) || out_pc_w[k] !== 32'h0000_3000) begin
                n_bad++;
                $display("FAIL full_stall d%0d: im_addr=%h head=%h required %h/00003000",
                         dep(k), im_addr_w[k], out_pc_w[k], 32'h0000_3000 + 32'(4 * dep(k)));
            end
        end
        out_ready = 1'b1;
        exp = 32'h0000_3000;
        for (int c = 0; c < 12; c++) begin
            tick();
            exp = exp + 32'd4;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== exp
                    || im_addr_w[k] !== exp + 32'(4 * dep(k))) begin
                    n_bad++;
                    $display("FAIL drain d%0d c%0d: valid=%b pc=%h im_addr=%h required pc=%h im_addr=%h",
                             dep(k), c, out_valid_w[k], out_pc_w[k], im_addr_w[k],
                             exp, exp + 32'(4 * dep(k)));
                end
            end
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3400; out_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_w[k] !== 1'b0 || im_addr_w[k] !== 32'h0000_3400) begin
                n_bad++;
                $display("FAIL redir_flush d%0d: valid=%b im_addr=%h required 0/00003400",
                         dep(k), out_valid_w[k], im_addr_w[k]);
            end
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== 32'h0000_3400 + 32'(4 * c)) begin
                    n_bad++;
                    $display("FAIL redir_stream d%0d c%0d: valid=%b pc=%h required %h",
                             dep(k), c, out_valid_w[k], out_pc_w[k], 32'h0000_3400 + 32'(4 * c));
                end
            end
        end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3402;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (fetch_err_w[k] !== 1'b1 || err_pc_w[k] !== 32'h0000_3402 || out_valid_w[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL halt d%0d c%0d: err=%b err_pc=%h valid=%b required 1/00003402/0",
                             dep(k), c, fetch_err_w[k], err_pc_w[k], out_valid_w[k]);
                end
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3500;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (fetch_err_w[k] !== 1'b0 || out_valid_w[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL halt_exit d%0d: err=%b valid=%b required 0/0",
                         dep(k), fetch_err_w[k], out_valid_w[k]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== 32'h0000_3500) begin
                n_bad++;
                $display("FAIL resume d%0d: valid=%b pc=%h required 1/00003500",
                         dep(k), out_valid_w[k], out_pc_w[k]);
            end
        end
    endtask

    task automatic test_en_low();
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (im_addr_w[k] !== 32'h0000_300C || out_valid_w[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL en_low d%0d c%0d: im_addr=%h valid=%b required 0000300c/0",
                             dep(k), c, im_addr_w[k], out_valid_w[k]);
                end
            end
        end
        en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== 32'h0000_300C + 32'(4 * c)) begin
                    n_bad++;
                    $display("FAIL en_resume d%0d c%0d: valid=%b pc=%h required %h",
                             dep(k), c, out_valid_w[k], out_pc_w[k], 32'h0000_300C + 32'(4 * c));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3402;
        tick();
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_3500; out_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_w[k] !== 1'b0 || fetch_err_w[k] !== 1'b0 || err_pc_w[k] !== 32'h0
                || im_addr_w[k] !== 32'h0000_3000) begin
                n_bad++;
                $display("FAIL mid_reset d%0d: valid=%b err=%b err_pc=%h im_addr=%h required 0/0/0/00003000",
                         dep(k), out_valid_w[k], fetch_err_w[k], err_pc_w[k], im_addr_w[k]);
            end
        end
        reset = 1'b1; redirect_valid = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (out_valid_w[k] !== 1'b1 || out_pc_w[k] !== 32'h0000_3000) begin
                n_bad++;
                $display("FAIL mid_reset_first d%0d: valid=%b pc=%h required 1/00003000",
                         dep(k), out_valid_w[k], out_pc_w[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset          = ($urandom_range(0, 99) != 0);
            en             = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 32'hFFFF_FFF0;
            else
                redirect_pc = 32'h0000_4000 + ($urandom_range(0, 255) << 2);
            if ($urandom_range(0, 3) == 0)
                redirect_pc[1:0] = 2'($urandom_range(1, 3));
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (out_valid_w[k] !== (m_cnt[k] != 0)) begin
                    n_bad++;
                    $display("FAIL rand_valid d%0d c%0d: got %b required %b",
                             dep(k), c, out_valid_w[k], (m_cnt[k] != 0));
                end
                if (m_cnt[k] != 0) begin
                    n_cmp++;
                    if (out_pc_w[k] !== m_q_pc[k][0] || out_instr_w[k] !== ~m_q_pc[k][0]) begin
                        n_bad++;
                        $display("FAIL rand_head d%0d c%0d: pc=%h instr=%h required %h/%h",
                                 dep(k), c, out_pc_w[k], out_instr_w[k], m_q_pc[k][0], ~m_q_pc[k][0]);
                    end
                end
                n_cmp++;
                if (im_addr_w[k] !== m_fpc[k]) begin
                    n_bad++;
                    $display("FAIL rand_addr d%0d c%0d: got %h required %h",
                             dep(k), c, im_addr_w[k], m_fpc[k]);
                end
                n_cmp++;
                if (fetch_err_w[k] !== m_err[k] || err_pc_w[k] !== m_errpc[k]) begin
                    n_bad++;
                    $display("FAIL rand_err d%0d c%0d: err=%b err_pc=%h required %b/%h",
                             dep(k), c, fetch_err_w[k], err_pc_w[k], m_err[k], m_errpc[k]);
                end
            end
        end
        reset = 1'b1; redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_pending();
        test_misaligned();
        test_en_low();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
